hazard_scoreboard_unit: RTL



---
 rtl/hazard_scoreboard_unit_if.sv | 45 ++++
 rtl/hazard_scoreboard_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard-unit bundle: pipeline addresses and controls in, forwarding selects
// and stall/flush controls out.
interface hazard_scoreboard_unit_if #(
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned NRD  = 2
);
    logic [NRD*AW-1:0] ra_d;
    logic [NRD*AW-1:0] ra_e;
    logic              valid_e;
    logic [AW-1:0]     wa_e;
    logic [AW-1:0]     wa_m;
    logic [AW-1:0]     wa_w;
    logic              reg_write_e;
    logic              reg_write_m;
    logic              reg_write_w;
    logic              mem_to_reg_e;
    logic              mem_done;
    logic [AW-1:0]     mem_done_wa;
    logic              pc_write_d;
    logic              branch_taken_e;
    logic [NRD*2-1:0]  forward_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic              pc_pending;
    logic [AW:0]       load_pending_cnt;

    modport master (
        output ra_d, ra_e, valid_e, wa_e, wa_m, wa_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e,
               mem_done, mem_done_wa, pc_write_d, branch_taken_e,
        input  forward_e, stall_f, stall_d, flush_d, flush_e,
               pc_pending, load_pending_cnt
    );

    modport slave (
        input  ra_d, ra_e, valid_e, wa_e, wa_m, wa_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e,
               mem_done, mem_done_wa, pc_write_d, branch_taken_e,
        output forward_e, stall_f, stall_d, flush_d, flush_e,
               pc_pending, load_pending_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding, load-use stall, outstanding-load scoreboard and PC-write
// flush sequencer for the F/D/E pipeline.
module hazard_scoreboard_unit #(
    parameter int unsigned NREG         = 16,
    parameter int unsigned AW           = $clog2(NREG),
    parameter int unsigned NRD          = 2,
    parameter int unsigned PC_FLUSH_CYC = 3,
    parameter bit          ZERO_REG_EN  = 1'b0
) (
    input logic                     clk,
    input logic                     rst_n,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int unsigned CW = (PC_FLUSH_CYC < 1) ? 1 : $clog2(PC_FLUSH_CYC + 1);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREG-1:0]   sb_q, sb_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [NRD*2-1:0]  fwd_c;
    logic              luse_c;
    logic              load_e_c;
    logic              set_c;
    logic              stall_f_c, stall_d_c, flush_d_c, flush_e_c, pc_pending_c;

    function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && !(ZERO_REG_EN && (a == '0));
    endfunction

    function automatic logic sb_hit(input logic [NREG-1:0] sb, input logic [AW-1:0] ra);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (AW'(i) == ra) hit = sb[i];
        end
        return hit;
    endfunction

    assign load_e_c = bus.valid_e && bus.mem_to_reg_e && bus.reg_write_e;
    assign set_c    = load_e_c && !bus.branch_taken_e;

    // E-stage operand forwarding, M beats W
    always_comb begin
        fwd_c = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (match(bus.ra_e[k*AW +: AW], bus.wa_m) && bus.reg_write_m)
                fwd_c[k*2 +: 2] = 2'b10;
            else if (match(bus.ra_e[k*AW +: AW], bus.wa_w) && bus.reg_write_w)
                fwd_c[k*2 +: 2] = 2'b01;
        end
    end

    // A load completing this cycle releases the dependent instruction at once
    always_comb begin
        luse_c = 1'b0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (match(bus.ra_d[k*AW +: AW], bus.wa_e) && load_e_c)
                luse_c = 1'b1;
            if (sb_hit(sb_q, bus.ra_d[k*AW +: AW]) &&
                !(bus.mem_done && match(bus.ra_d[k*AW +: AW], bus.mem_done_wa)))
                luse_c = 1'b1;
        end
    end

    // Scoreboard next state: clear first so a colliding new load stays outstanding
    always_comb begin
        sb_d   = sb_q;
        pcnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (bus.mem_done && match(AW'(i), bus.mem_done_wa)) sb_d[i] = 1'b0;
            if (set_c && match(AW'(i), bus.wa_e))               sb_d[i] = 1'b1;
        end
        for (int unsigned i = 0; i < NREG; i++) begin
            pcnt_d = pcnt_d + PW'(sb_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sb_q    <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sb_q    <= sb_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // PC-write sequencer next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.pc_write_d && !luse_c && !bus.branch_taken_e) begin
                    state_d = PEND;
                    cnt_d   = CW'(PC_FLUSH_CYC);
                end
            end
            PEND: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
        endcase
    end

    // Pipeline controls; the final PEND cycle (cnt 0) still flushes D
    always_comb begin
        stall_d_c    = luse_c;
        stall_f_c    = luse_c || (bus.pc_write_d && (state_q == IDLE)) ||
                       ((state_q == PEND) && (cnt_q != '0));
        flush_e_c    = luse_c || bus.branch_taken_e;
        flush_d_c    = bus.branch_taken_e ||
                       (bus.pc_write_d && (state_q == IDLE) && !luse_c) ||
                       (state_q == PEND);
        pc_pending_c = (state_q == PEND);
    end

    assign bus.forward_e        = fwd_c;
    assign bus.stall_f          = stall_f_c;
    assign bus.stall_d          = stall_d_c;
    assign bus.flush_d          = flush_d_c;
    assign bus.flush_e          = flush_e_c;
    assign bus.pc_pending       = pc_pending_c;
    assign bus.load_pending_cnt = pcnt_q;
endmodule
